// File: rtl/dsm_pkg.sv
// Shared state encoding and constants for the delta-sigma DAC sequencer.
package dsm_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle     = 2'd0,
        StRampUp   = 2'd1,
        StRun      = 2'd2,
        StRampDown = 2'd3
    } dsm_state_e;

    // Most negative two's-complement value for a given sample width.
    function automatic longint dsm_min(input int unsigned width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/dsm_tick_gen.sv
// Clock divider and OSR counter: modulator strobe plus sample-boundary flag.
module dsm_tick_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OSR     = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_strobe,
    output logic o_boundary
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OsrW = $clog2(OSR);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [OsrW-1:0] OsrLast = OsrW'(OSR - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);
    localparam logic [OsrW-1:0] OsrOne  = OsrW'(1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [OsrW-1:0] osr_cnt_q, osr_cnt_d;
    logic            strobe;

    always_comb begin
        strobe    = i_en && (div_cnt_q == DivLast);
        div_cnt_d = div_cnt_q;
        osr_cnt_d = osr_cnt_q;
        if (!i_en) begin
            // Counters parked at zero so the first strobe lands CLK_DIV cycles after enable.
            div_cnt_d = '0;
            osr_cnt_d = '0;
        end else begin
            div_cnt_d = strobe ? '0 : div_cnt_q + DivOne;
            if (strobe) begin
                osr_cnt_d = (osr_cnt_q == OsrLast) ? '0 : osr_cnt_q + OsrOne;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= '0;
            osr_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            osr_cnt_q <= osr_cnt_d;
        end
    end

    assign o_strobe   = strobe;
    assign o_boundary = strobe && (osr_cnt_q == OsrLast);

endmodule

// File: rtl/dsm_dac_ctrl.sv
// Delta-sigma DAC sequencer: strobe pacing, one-entry sample holding register and
// pop-free ramps between full-scale-negative and zero on start/stop.
module dsm_dac_ctrl
    import dsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned OSR        = 64,
    parameter int unsigned RAMP_STEP  = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic signed [DATA_WIDTH-1:0] i_s_data,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic                         i_clr_underrun,
    output logic                         o_dsm_en,
    output logic signed [DATA_WIDTH-1:0] o_dsm_data,
    output logic                         o_underrun,
    output logic                         o_busy
);

    localparam int unsigned ExtW = DATA_WIDTH + 1;
    localparam logic signed [DATA_WIDTH-1:0] MinVal  = DATA_WIDTH'(dsm_min(DATA_WIDTH));
    localparam logic signed [ExtW-1:0]       MinExt  = ExtW'(dsm_min(DATA_WIDTH));
    localparam logic signed [ExtW-1:0]       StepExt = ExtW'(RAMP_STEP);

    dsm_state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic signed [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                         hold_valid_q, hold_valid_d;
    logic                         underrun_q, underrun_d;
    logic                         busy_q, busy_d;

    logic                   tick_en;
    logic                   strobe;
    logic                   boundary;
    logic                   ready;
    logic                   accept;
    logic signed [ExtW-1:0] data_ext;
    logic signed [ExtW-1:0] up_sum;
    logic signed [ExtW-1:0] dn_diff;

    assign tick_en = (state_q != StIdle);

    dsm_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .OSR     (OSR)
    ) u_tick_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (tick_en),
        .o_strobe   (strobe),
        .o_boundary (boundary)
    );

    assign ready  = (state_q != StIdle) && !hold_valid_q;
    assign accept = i_s_valid && ready;

    // One extra bit keeps the ramp sums free of overflow before clamping.
    always_comb begin
        data_ext = {data_q[DATA_WIDTH-1], data_q};
        up_sum   = data_ext + StepExt;
        dn_diff  = data_ext - StepExt;
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        underrun_d   = underrun_q;

        if (i_clr_underrun) begin
            underrun_d = 1'b0;
        end

        // Ready is low whenever a boundary could consume the register, so no collision.
        if (accept) begin
            hold_data_d  = i_s_data;
            hold_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                data_d       = MinVal;
                hold_valid_d = 1'b0;
                if (i_start) begin
                    state_d = StRampUp;
                end
            end

            StRampUp: begin
                if (i_stop) begin
                    state_d = StRampDown;
                end else if (boundary) begin
                    if (!up_sum[ExtW-1]) begin
                        data_d  = '0;
                        state_d = StRun;
                    end else begin
                        data_d = up_sum[DATA_WIDTH-1:0];
                    end
                end
            end

            StRun: begin
                if (i_stop) begin
                    state_d = StRampDown;
                end else if (boundary) begin
                    if (hold_valid_q) begin
                        data_d       = hold_data_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end

            StRampDown: begin
                if (boundary) begin
                    if (dn_diff <= MinExt) begin
                        data_d       = MinVal;
                        hold_valid_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        data_d = dn_diff[DATA_WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            data_q       <= MinVal;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            underrun_q   <= underrun_d;
            busy_q       <= busy_d;
        end
    end

    assign o_s_ready  = ready;
    assign o_dsm_en   = strobe;
    assign o_dsm_data = data_q;
    assign o_underrun = underrun_q;
    assign o_busy     = busy_q;

endmodule
